// File: rtl/present_pkg.sv
// Shared constants for the PRESENT substitution layer: S-box tables and FSM encoding.
// Tables are packed so that entry x sits in nibble x (entry 0 in the least significant nibble).
package present_pkg;

    localparam int STATE_W_DEF = 64;

    localparam logic [15:0][3:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [15:0][3:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/present_sbox_nibble.sv
// One 4-bit PRESENT S-box lookup. The inv input selects between S and S^-1.
module present_sbox_nibble
    import present_pkg::*;
(
    input  logic [3:0] x,
    input  logic       inv,
    output logic [3:0] y
);

    assign y = inv ? SBOX_INV[x] : SBOX[x];

endmodule

// File: rtl/present_sbox_layer_serial.sv
// PRESENT S-box layer over a full cipher state. NPC nibbles are substituted per clock while the
// state rotates through a shift register.
//
// Handshake rules, both ports: a beat transfers on a rising edge where valid and ready are both
// high. The producer holds valid and its data stable until that edge. in_ready is high only in
// IDLE and out_valid only in DONE, so the block never accepts and delivers in the same cycle.
module present_sbox_layer_serial
    import present_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int NPC     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int SW = 4 * NPC;
    localparam int N  = STATE_W / SW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    generate
        if (NPC < 1 || (STATE_W % SW) != 0) begin : g_bad_params
            $error("STATE_W must be a nonzero multiple of 4*NPC");
        end
    endgenerate

    state_t             state, state_next;
    logic [STATE_W-1:0] sr;
    logic [CW-1:0]      cnt;
    logic               mode;
    logic [SW-1:0]      sub_w;
    logic [STATE_W-1:0] sr_rot;
    logic               accept;
    logic               last;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (cnt == CNT_LAST);

    for (genvar i = 0; i < NPC; i++) begin : g_sbox
        present_sbox_nibble u_nib (
            .x   (sr[4*i +: 4]),
            .inv (mode),
            .y   (sub_w[4*i +: 4])
        );
    end

    // Substituted low slice re-enters at the top; with N == 1 it is the whole state.
    generate
        if (N == 1) begin : g_rot_full
            assign sr_rot = sub_w;
        end else begin : g_rot_part
            assign sr_rot = {sub_w, sr[STATE_W-1:SW]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state == BUSY) || (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            mode <= 1'b0;
        end else if (accept) begin
            sr   <= in_data;
            cnt  <= '0;
            mode <= in_inv;
        end else if (state == BUSY) begin
            sr <= sr_rot;
            if (!last) cnt <= cnt + 1'b1;
        end
    end

    assign out_data  = sr;
    assign dbg_state = state;

endmodule

// File: tb/tb_present_sbox_layer_serial.sv
// Bench for the PRESENT S-box layer: three instances (NPC = 4, 1, 16) driven by directed
// steps and random states, checked against a nibble-table model and an expected-value queue.
module tb_present_sbox_layer_serial;

    localparam int W = 64;
    localparam int LAT [3] = '{4, 16, 1};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   in_valid = '0;
    logic [2:0]   in_ready;
    logic [W-1:0] in_data [3];
    logic [2:0]   in_inv = '0;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready = '0;
    logic [W-1:0] out_data [3];
    logic [2:0]   busy;
    logic [1:0]   dbg_state [3];

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    logic [3:0] s_tab  [16] = '{4'hC,4'h5,4'h6,4'hB,4'h9,4'h0,4'hA,4'hD,4'h3,4'hE,4'hF,4'h8,4'h4,4'h7,4'h1,4'h2};
    logic [3:0] si_tab [16] = '{4'h5,4'hE,4'hF,4'h8,4'hC,4'h1,4'h2,4'hD,4'hB,4'h4,4'h6,4'h3,4'h0,4'h7,4'h9,4'hA};

    always #5 clk = ~clk;

    present_sbox_layer_serial #(.STATE_W(64), .NPC(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_inv(in_inv[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]), .dbg_state(dbg_state[0]));
    present_sbox_layer_serial #(.STATE_W(64), .NPC(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_inv(in_inv[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]), .dbg_state(dbg_state[1]));
    present_sbox_layer_serial #(.STATE_W(64), .NPC(16)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .in_inv(in_inv[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2]), .dbg_state(dbg_state[2]));

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W / 4; k++)
            r[4*k +: 4] = inv ? si_tab[d[4*k +: 4]] : s_tab[d[4*k +: 4]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one state; returns once out_valid is high (or the wait budget expires).
    task automatic start_txn(input int idx, input logic [W-1:0] d, input logic inv, output bit ok);
        int lat;
        @(negedge clk);
        in_data[idx]  = d;
        in_inv[idx]   = inv;
        in_valid[idx] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        in_data[idx]  = ~d;
        in_inv[idx]   = ~inv;
        lat = 0;
        while (!out_valid[idx] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = out_valid[idx];
        check($sformatf("latency u%0d", idx), W'(lat), W'(LAT[idx]));
    endtask

    task automatic finish_txn(input int idx, output logic [W-1:0] got);
        logic [W-1:0] exp;
        got = out_data[idx];
        exp = exp_q.pop_front();
        check($sformatf("data u%0d", idx), got, exp);
        @(negedge clk);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        check($sformatf("out_valid drop u%0d", idx), W'(out_valid[idx]), W'(0));
        check($sformatf("in_ready back u%0d", idx), W'(in_ready[idx]), W'(1));
    endtask

    task automatic run_txn(input int idx, input logic [W-1:0] d, input logic inv, output logic [W-1:0] got);
        bit ok;
        exp_q.push_back(model(d, inv));
        start_txn(idx, d, inv, ok);
        if (!ok) begin
            void'(exp_q.pop_front());
            check($sformatf("timeout u%0d", idx), W'(0), W'(1));
            got = '0;
        end else begin
            finish_txn(idx, got);
        end
    endtask

    initial begin
        logic [W-1:0] got, x, y, held;
        bit ok;
        for (int i = 0; i < 3; i++) in_data[i] = '0;

        // Reset state, in_ready held low while rst is high.
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst in_ready u%0d", i), W'(in_ready[i]), W'(0));
            check($sformatf("rst out_valid u%0d", i), W'(out_valid[i]), W'(0));
            check($sformatf("rst out_data u%0d", i), out_data[i], W'(0));
            check($sformatf("rst busy u%0d", i), W'(busy[i]), W'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle in_ready u0", W'(in_ready[0]), W'(1));

        // Directed vectors on every instance.
        for (int i = 0; i < 3; i++) begin
            run_txn(i, 64'h0123456789ABCDEF, 1'b0, got);
            check($sformatf("vec1 const u%0d", i), got, 64'hC56B90AD3EF84712);
            run_txn(i, 64'hC56B90AD3EF84712, 1'b1, got);
            check($sformatf("vec2 const u%0d", i), got, 64'h0123456789ABCDEF);
        end
        run_txn(0, 64'h0, 1'b0, got);
        check("zero fwd", got, 64'hCCCCCCCCCCCCCCCC);
        run_txn(0, 64'h0, 1'b1, got);
        check("zero inv", got, 64'h5555555555555555);

        // Backpressure in DONE with a competing in_valid.
        exp_q.push_back(model(64'h0123456789ABCDEF, 1'b0));
        start_txn(0, 64'h0123456789ABCDEF, 1'b0, ok);
        held = out_data[0];
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 64'hDEADBEEF_00000000;
        in_inv[0]   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp data stable", out_data[0], held);
            check("bp out_valid", W'(out_valid[0]), W'(1));
            check("bp in_ready", W'(in_ready[0]), W'(0));
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        finish_txn(0, got);
        @(posedge clk);
        #1;
        check("bp no extra beat", W'(out_valid[0]), W'(0));
        check("bp no extra busy", W'(busy[0]), W'(0));

        // Reset while BUSY with cnt == 2.
        @(negedge clk);
        in_data[0]  = 64'h0123456789ABCDEF;
        in_inv[0]   = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst out_valid", W'(out_valid[0]), W'(0));
        check("midrst out_data", out_data[0], W'(0));
        check("midrst busy", W'(busy[0]), W'(0));
        check("midrst in_ready", W'(in_ready[0]), W'(0));
        check("midrst state", W'(dbg_state[0]), W'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("midrst no output", W'(out_valid[0]), W'(0));
        end
        run_txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, got);
        check("ones fwd", got, 64'h2222222222222222);

        // Random round trips.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < ((i == 0) ? 1000 : 200); n++) begin
                x = {$urandom, $urandom};
                run_txn(i, x, 1'b0, y);
                run_txn(i, y, 1'b1, got);
                check($sformatf("roundtrip u%0d", i), got, x);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
